noc_flit_sink: RTL and testbench

Single-clock ejection stage directly downstream of the router's local output port (port 0). Accepts credit-flow-controlled flits (data, dest, is_tail, send), buffers them, and presents them as an AXI-Stream master with tlast/tid/tdest. Returns one credit per flit drained and checks link protocol. Used in the SINGLE_CLOCK, SERIALIZATION_FACTOR=1 configuration in place of the deserializer shim.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/noc_flit_fifo.sv | 44 ++++
 rtl/noc_flit_sink.sv | 105 ++++++++++
 tb/tb_noc_flit_sink.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types for the NoC ejection path: flit bundle and sink FSM states.
package noc_pkg;

    localparam int FLIT_W  = 64;
    localparam int TID_W   = 2;
    localparam int TDEST_W = 4;
    localparam int DEST_W  = TDEST_W + TID_W;

    typedef struct packed {
        logic [FLIT_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic              is_tail;
    } flit_t;

    typedef enum logic {
        IDLE,
        IN_PKT
    } sink_state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// First-word-fall-through flit buffer with wrap-bit pointers.
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  flit_t wdata,
    output flit_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    flit_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Same index with differing wrap bits means the buffer is full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/noc_flit_sink.sv
// Router local-port ejection stage: credit-flow flits in, AXI-Stream out,
// one credit back per drained flit, with overflow and packet-dest checks.
module noc_flit_sink
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH    = FLIT_W,
    parameter int TID_WIDTH     = TID_W,
    parameter int TDEST_WIDTH   = TDEST_W,
    parameter int DEST_WIDTH    = TDEST_WIDTH + TID_WIDTH,
    parameter int BUFFER_DEPTH  = 2,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                     clk_noc,
    input  logic                     rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0]    data_in,
    input  logic [DEST_WIDTH-1:0]    dest_in,
    input  logic                     is_tail_in,
    input  logic                     send_in,
    output logic                     credit_out,
    output logic                     axis_out_tvalid,
    input  logic                     axis_out_tready,
    output logic [FLIT_WIDTH-1:0]    axis_out_tdata,
    output logic                     axis_out_tlast,
    output logic [TID_WIDTH-1:0]     axis_out_tid,
    output logic [TDEST_WIDTH-1:0]   axis_out_tdest,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count,
    output logic                     overflow_err,
    output logic                     protocol_err
);

    localparam logic [PKT_CNT_WIDTH-1:0] CNT_ONE = 1;

    flit_t       wdata;
    flit_t       rdata;
    logic        full;
    logic        empty;
    logic        pop;
    logic        wr_en;
    sink_state_e state;
    logic [DEST_WIDTH-1:0] head_dest;

    assign wdata.data    = data_in;
    assign wdata.dest    = dest_in;
    assign wdata.is_tail = is_tail_in;

    assign axis_out_tvalid = !empty;
    assign pop   = axis_out_tvalid && axis_out_tready;
    // A full buffer still takes a flit when a slot frees in the same cycle.
    assign wr_en = send_in && (!full || pop);

    assign axis_out_tdata = axis_out_tvalid ? rdata.data : '0;
    assign axis_out_tlast = axis_out_tvalid && rdata.is_tail;
    assign axis_out_tid   = axis_out_tvalid ?
                            rdata.dest[DEST_WIDTH-1:TDEST_WIDTH] : '0;
    assign axis_out_tdest = axis_out_tvalid ?
                            rdata.dest[TDEST_WIDTH-1:0] : '0;

    noc_flit_fifo #(
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk   (clk_noc),
        .rst   (rst_noc_sync),
        .push  (wr_en),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            credit_out   <= 1'b0;
            pkt_count    <= '0;
            overflow_err <= 1'b0;
        end else begin
            credit_out <= pop;
            if (pop && rdata.is_tail) pkt_count <= pkt_count + CNT_ONE;
            if (send_in && full && !pop) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state        <= IDLE;
            head_dest    <= '0;
            protocol_err <= 1'b0;
        end else if (wr_en) begin
            unique case (state)
                IDLE: begin
                    if (!is_tail_in) begin
                        head_dest <= dest_in;
                        state     <= IN_PKT;
                    end
                end
                IN_PKT: begin
                    if (dest_in != head_dest) protocol_err <= 1'b1;
                    if (is_tail_in) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_flit_sink.sv
// Randomised bench for noc_flit_sink against a queue-based reference model.
module tb_noc_flit_sink;

    localparam int DEPTH = 2;
    localparam int PW    = 8;

    logic          clk = 0;
    logic          rst = 0;
    logic [63:0]   data = 0;
    logic [5:0]    dest = 0;
    logic          tail = 0;
    logic          send = 0;
    logic          rdy  = 0;
    logic          credit_out;
    logic          axis_out_tvalid;
    logic [63:0]   axis_out_tdata;
    logic          axis_out_tlast;
    logic [1:0]    axis_out_tid;
    logic [3:0]    axis_out_tdest;
    logic [PW-1:0] pkt_count;
    logic          overflow_err;
    logic          protocol_err;

    noc_flit_sink #(
        .BUFFER_DEPTH  (DEPTH),
        .PKT_CNT_WIDTH (PW)
    ) dut (
        .clk_noc         (clk),
        .rst_noc_sync    (rst),
        .data_in         (data),
        .dest_in         (dest),
        .is_tail_in      (tail),
        .send_in         (send),
        .credit_out      (credit_out),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (rdy),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tid    (axis_out_tid),
        .axis_out_tdest  (axis_out_tdest),
        .pkt_count       (pkt_count),
        .overflow_err    (overflow_err),
        .protocol_err    (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [5:0]  dst;
        logic        t;
    } fl_t;

    fl_t         mq[$];
    int unsigned m_pkts;
    int unsigned m_beats;
    bit          m_ovf, m_perr, m_inpkt, m_credit;
    logic [5:0]  m_head;
    int          mdl_err;
    string       mdl_msg;

    logic          o_tvalid, o_tlast, o_credit, o_ovf, o_perr;
    logic [63:0]   o_tdata;
    logic [1:0]    o_tid;
    logic [3:0]    o_tdest;
    logic [PW-1:0] o_pkt;
    int            n_credit;
    int            cr;

    int total = 0;
    int bad   = 0;

    task automatic note(input string s);
        if (mdl_err == 0) mdl_msg = s;
        mdl_err++;
    endtask

    task automatic drive(input bit s, input logic [63:0] d,
                         input logic [5:0] dst, input bit t, input bit r);
        send = s; data = d; dest = dst; tail = t; rdy = r;
    endtask

    task automatic model_clear();
        mq.delete();
        m_pkts = 0; m_ovf = 0; m_perr = 0; m_inpkt = 0;
        m_head = 0; m_credit = 0;
    endtask

    // One clock: snapshot outputs before the edge, compare to the model,
    // then advance the model by the inputs presented this cycle.
    task automatic cycle();
        fl_t f;
        bit pop, acc;
        logic [63:0] ed;
        logic [5:0] edst;
        logic et, ev;
        @(negedge clk);
        o_tvalid = axis_out_tvalid; o_tdata = axis_out_tdata;
        o_tlast = axis_out_tlast; o_tid = axis_out_tid;
        o_tdest = axis_out_tdest; o_credit = credit_out;
        o_pkt = pkt_count; o_ovf = overflow_err; o_perr = protocol_err;
        if (o_credit === 1'b1) begin n_credit++; cr++; end
        ev = mq.size() > 0;
        ed = ev ? mq[0].d : 64'h0;
        edst = ev ? mq[0].dst : 6'h0;
        et = ev ? mq[0].t : 1'b0;
        if ({o_tvalid, o_tdata, o_tlast, o_tid, o_tdest} !==
            {ev, ed, et, edst[5:4], edst[3:0]})
            note($sformatf("axis got v=%b d=%h l=%b id=%h de=%h want v=%b d=%h l=%b dst=%h",
                 o_tvalid, o_tdata, o_tlast, o_tid, o_tdest, ev, ed, et, edst));
        if (o_credit !== m_credit)
            note($sformatf("credit got %b want %b", o_credit, m_credit));
        if (o_pkt !== PW'(m_pkts))
            note($sformatf("pkt_count got %0d want %0d", o_pkt, PW'(m_pkts)));
        if (o_ovf !== m_ovf)
            note($sformatf("overflow got %b want %b", o_ovf, m_ovf));
        if (o_perr !== m_perr)
            note($sformatf("protocol got %b want %b", o_perr, m_perr));
        pop = (mq.size() > 0) && rdy;
        acc = send && ((mq.size() < DEPTH) || pop);
        if (send && !acc) m_ovf = 1;
        if (acc) begin
            if (m_inpkt && dest != m_head) m_perr = 1;
            if (!m_inpkt && !tail) begin
                m_inpkt = 1;
                m_head = dest;
            end else if (tail) begin
                m_inpkt = 0;
            end
        end
        if (pop) begin
            f = mq.pop_front();
            m_beats++;
            if (f.t) m_pkts++;
        end
        if (acc) mq.push_back('{d: data, dst: dest, t: tail});
        m_credit = pop;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        total++;
        if (mdl_err !== 0) begin
            bad++;
            $display("FAIL %s: %0d model mismatches (required 0), first: %s",
                     name, mdl_err, mdl_msg);
        end
        mdl_err = 0;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
        cr = DEPTH;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic test_reset();
        apply_reset();
        drive(0, 0, 0, 0, 0);
        cycle();
        total++;
        if ({o_tvalid, o_tdata, o_tlast, o_tid, o_tdest} !== 72'h0) begin
            bad++;
            $display("FAIL reset_axis: got v=%b d=%h required all 0", o_tvalid, o_tdata);
        end
        total++;
        if ({o_credit, o_pkt, o_ovf, o_perr} !== '0) begin
            bad++;
            $display("FAIL reset_status: got cr=%b pkt=%0d ovf=%b perr=%b required 0",
                     o_credit, o_pkt, o_ovf, o_perr);
        end
        check_model("reset_model");
    endtask

    task automatic test_single();
        drive(1, 64'hDEAD_BEEF, 6'b10_0101, 1, 1);
        cycle();
        drive(0, 0, 0, 0, 1);
        cycle();
        total++;
        if ({o_tvalid, o_tid, o_tdest, o_tlast, o_tdata} !==
            {1'b1, 2'd2, 4'd5, 1'b1, 64'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL single_beat: got v=%b id=%0d de=%0d l=%b d=%h required 1 2 5 1 deadbeef",
                     o_tvalid, o_tid, o_tdest, o_tlast, o_tdata);
        end
        cycle();
        total++;
        if (o_credit !== 1'b1 || o_pkt !== PW'(1)) begin
            bad++;
            $display("FAIL single_credit: got credit=%b pkt=%0d required 1 1", o_credit, o_pkt);
        end
        idle(2);
        check_model("single_model");
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int c0, b0, p0, unstable = 0;
        logic [63:0] first;
        idle(3);
        cr = DEPTH;
        c0 = n_credit; b0 = m_beats; p0 = m_pkts;
        first = 64'h1000 + 64'($urandom_range(0, 255));
        for (int i = 0; i < 30; i++) begin
            if (sent < 4 && cr > 0) begin
                drive(1, (sent == 0) ? first : 64'($urandom), 6'h2A, sent == 3, i >= 10);
                sent++;
                cr--;
            end else begin
                drive(0, 0, 0, 0, i >= 10);
            end
            cycle();
            if (i >= 2 && i < 10 && (o_tvalid !== 1'b1 || o_tdata !== first))
                unstable++;
        end
        total++;
        if (unstable !== 0) begin
            bad++;
            $display("FAIL bp_stable: %0d unstable stall cycles, required 0", unstable);
        end
        total++;
        if (n_credit - c0 !== 4 || int'(m_beats - b0) !== 4 || o_pkt !== PW'(p0 + 1)) begin
            bad++;
            $display("FAIL bp_counts: credits=%0d beats=%0d pkt=%0d required 4 4 %0d",
                     n_credit - c0, m_beats - b0, o_pkt, PW'(p0 + 1));
        end
        check_model("bp_model");
    endtask

    task automatic test_overflow();
        int b0;
        b0 = m_beats;
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'hA000 + 64'(i), 6'h11, 1, 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0);
        cycle();
        total++;
        if (o_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag: got %b required 1", o_ovf);
        end
        idle(4);
        total++;
        if (int'(m_beats - b0) !== 2) begin
            bad++;
            $display("FAIL ovf_beats: model beats %0d required 2", m_beats - b0);
        end
        check_model("ovf_model");
    endtask

    task automatic test_protocol();
        drive(1, 64'h51, 6'h05, 0, 1); cycle();
        drive(1, 64'h52, 6'h05, 0, 1); cycle();
        drive(1, 64'h53, 6'h06, 1, 1); cycle();
        total++;
        if (o_perr !== 1'b0) begin
            bad++;
            $display("FAIL perr_early: got %b required 0", o_perr);
        end
        drive(0, 0, 0, 0, 1);
        cycle();
        total++;
        if (o_perr !== 1'b1) begin
            bad++;
            $display("FAIL perr_flag: got %b required 1", o_perr);
        end
        idle(3);
        check_model("perr_model");
    endtask

    task automatic test_wrap();
        int c0;
        apply_reset();
        c0 = n_credit;
        for (int i = 0; i < 259; i++) begin
            drive(1, 64'($urandom), 6'($urandom), 1, i >= 2);
            cycle();
        end
        idle(5);
        total++;
        if (o_pkt !== PW'(3) || o_ovf !== 1'b0) begin
            bad++;
            $display("FAIL wrap_count: got pkt=%0d ovf=%b required 3 0", o_pkt, o_ovf);
        end
        total++;
        if (n_credit - c0 !== 259) begin
            bad++;
            $display("FAIL wrap_credits: got %0d required 259", n_credit - c0);
        end
        check_model("wrap_model");
    endtask

    task automatic test_reset_mid();
        int c0;
        drive(1, 64'hB1, 6'h09, 0, 0); cycle();
        drive(1, 64'hB2, 6'h09, 0, 0); cycle();
        apply_reset();
        c0 = n_credit;
        drive(0, 0, 0, 0, 1);
        cycle();
        total++;
        if ({o_tvalid, o_tdata, o_credit, o_pkt, o_ovf, o_perr} !== '0) begin
            bad++;
            $display("FAIL rstmid_out: got v=%b d=%h cr=%b pkt=%0d ovf=%b perr=%b required 0",
                     o_tvalid, o_tdata, o_credit, o_pkt, o_ovf, o_perr);
        end
        idle(3);
        total++;
        if (n_credit !== c0) begin
            bad++;
            $display("FAIL rstmid_credit: got %0d pulses required 0", n_credit - c0);
        end
        drive(1, 64'hC1, 6'h33, 0, 1); cycle();
        drive(1, 64'hC2, 6'h33, 1, 1); cycle();
        idle(3);
        total++;
        if (o_pkt !== PW'(1) || n_credit - c0 !== 2) begin
            bad++;
            $display("FAIL rstmid_after: got pkt=%0d credits=%0d required 1 2",
                     o_pkt, n_credit - c0);
        end
        check_model("rstmid_model");
    endtask

    task automatic test_random();
        logic [5:0] pd;
        pd = 6'($urandom);
        idle(3);
        cr = DEPTH;
        for (int i = 0; i < 400; i++) begin
            if (cr > 0 && $urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 9) == 0) pd = 6'($urandom);
                drive(1, {$urandom, $urandom}, pd, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 2) != 0);
                cr--;
            end else begin
                drive(0, 0, 0, 0, $urandom_range(0, 2) != 0);
            end
            cycle();
        end
        idle(4);
        check_model("random_model");
    endtask

    initial begin
        mdl_err = 0; n_credit = 0; cr = DEPTH; m_beats = 0;
        model_clear();
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_protocol();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
